dmem_arbiter: RTL and testbench

Two-port arbiter and sequencer in front of the single-ported `data_memory`. It shares the memory between the CPU load/store path (port 0) and the debug/loader path (port 1), with round-robin fairness. It turns each granted request into a clean one-cycle `memRead`/`memWrite` access, captures read data into a register, and returns a one-cycle acknowledge. Every `data_memory` control and address input is driven only by this block.

---
 rtl/dmem_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin two-port arbiter/sequencer in front of a
// single-ported data memory. Each granted request becomes one clean
// memRead/memWrite cycle followed by a one-cycle acknowledge.

// Per-port completion state: registered read data and error flag,
// plus the acknowledge pulse decoded from the shared sequencer.
module dmem_arb_lane (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,      // this port granted (IDLE -> ACCESS)
  input  logic        access,    // ACCESS cycle owned by this port
  input  logic        done,      // DONE cycle owned by this port
  input  logic        rd,        // latched access is a read
  input  logic        in_range,  // latched address is inside the memory
  input  logic [31:0] mem_rdata,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        err
);

  assign ack = done;

  // Read data is only replaced by a completed read; writes leave it alone.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      rdata <= '0;
    else if (access && rd)
      rdata <= in_range ? mem_rdata : 32'h0;
  end

  // Error flag clears on grant and sets when the access is suppressed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      err <= 1'b0;
    else if (load)
      err <= 1'b0;
    else if (access && !in_range)
      err <= 1'b1;
  end

endmodule

module dmem_arbiter #(
  parameter int DEPTH = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        we0,
  input  logic [31:0] addr0,
  input  logic [31:0] wdata0,
  output logic        ack0,
  output logic [31:0] rdata0,
  output logic        err0,
  input  logic        req1,
  input  logic        we1,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata1,
  output logic        ack1,
  output logic [31:0] rdata1,
  output logic        err1,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int          NUM_PORTS = 2;
  localparam logic [31:0] DEPTH_W   = 32'(DEPTH);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  state_t                           state_q, state_d;
  logic                             last_q;   // port served most recently
  logic                             sel_q;    // port owning the current access
  req_t                             cur_q;    // latched winning request
  logic                             win;
  logic                             grant;
  logic                             in_range;

  logic [NUM_PORTS-1:0]             req_v;
  req_t [NUM_PORTS-1:0]             req_in;
  logic [NUM_PORTS-1:0]             ack_v;
  logic [NUM_PORTS-1:0]             err_v;
  logic [NUM_PORTS-1:0][31:0]       rdata_v;

  assign req_v     = {req1, req0};
  assign req_in[0] = {we0, addr0, wdata0};
  assign req_in[1] = {we1, addr1, wdata1};

  assign {ack1, ack0}     = ack_v;
  assign {err1, err0}     = err_v;
  assign rdata0           = rdata_v[0];
  assign rdata1           = rdata_v[1];

  // Full 32-bit unsigned compare so huge addresses never alias into range.
  assign in_range = (cur_q.addr < DEPTH_W);

  // Round-robin pick: a lone requester wins; on contention the port not
  // served last time wins.
  always_comb begin
    win = req_v[1];
    if (req_v == 2'b11)
      win = ~last_q;
  end

  assign grant = (state_q == IDLE) && (|req_v);

  // Sequencer state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  // Winner capture and fairness history.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sel_q  <= 1'b0;
      last_q <= 1'b1;
      cur_q  <= '0;
    end else begin
      if (grant) begin
        sel_q <= win;
        cur_q <= req_in[win];
      end
      if (state_q == DONE)
        last_q <= sel_q;
    end
  end

  // Next state and memory strobes; strobes live only in ACCESS so each
  // write is exactly one clean pulse, and reset kills them immediately.
  always_comb begin
    state_d   = state_q;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      IDLE:   if (|req_v) state_d = ACCESS;
      ACCESS: begin
        state_d = DONE;
        if (in_range) begin
          mem_read  = ~cur_q.we;
          mem_write = cur_q.we;
          mem_addr  = cur_q.addr;
          mem_wdata = cur_q.wdata;
        end
      end
      DONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_lane
    dmem_arb_lane u_lane (
      .clk       (clk),
      .rst       (rst),
      .load      (grant && (win == 1'(i))),
      .access    ((state_q == ACCESS) && (sel_q == 1'(i))),
      .done      ((state_q == DONE) && (sel_q == 1'(i))),
      .rd        (~cur_q.we),
      .in_range  (in_range),
      .mem_rdata (mem_rdata),
      .ack       (ack_v[i]),
      .rdata     (rdata_v[i]),
      .err       (err_v[i])
    );
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a behavioural memory stands in for data_memory,
// and a transaction-level model predicts grant order, ack timing, err and
// read data.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, we0, req1, we1;
  logic [31:0] addr0, wdata0, addr1, wdata1;
  logic        ack0, err0, ack1, err1;
  logic [31:0] rdata0, rdata1;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  dmem_arbiter #(.DEPTH(64)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .ack0(ack0), .rdata0(rdata0), .err0(err0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .ack1(ack1), .rdata1(rdata1), .err1(err1),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Stand-in data_memory with a preload port for the bench.
  logic [31:0] dmem [0:63];
  logic        pl_en = 1'b0;
  logic [5:0]  pl_addr = '0;
  logic [31:0] pl_data = '0;

  always @(posedge clk) begin
    if (pl_en) dmem[pl_addr] <= pl_data;
    else if (mem_write && mem_addr < 64) dmem[mem_addr[5:0]] <= mem_wdata;
  end
  assign mem_rdata = (mem_addr < 64) ? dmem[mem_addr[5:0]] : 32'h0;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] ref_mem [64];
  logic [31:0] exp_rdata [2];
  int          last_port;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int p, input bit r, input txn_t t);
    if (p == 0) begin req0 = r; we0 = t.we; addr0 = t.addr; wdata0 = t.wdata; end
    else        begin req1 = r; we1 = t.we; addr1 = t.addr; wdata1 = t.wdata; end
  endtask

  task automatic do_reset();
    txn_t z;
    z = '{0, 32'h0, 32'h0};
    rst = 1'b0;
    drive(0, 0, z);
    drive(1, 0, z);
    repeat (2) @(negedge clk);
    check("rst_acks", {30'h0, ack1, ack0}, 32'h0);
    check("rst_errs", {30'h0, err1, err0}, 32'h0);
    check("rst_rdata0", rdata0, 32'h0);
    check("rst_rdata1", rdata1, 32'h0);
    check("rst_mem_ctl", {30'h0, mem_read, mem_write}, 32'h0);
    check("rst_mem_bus", mem_addr | mem_wdata, 32'h0);
    rst = 1'b1;
    last_port = 1;
    exp_rdata[0] = 32'h0;
    exp_rdata[1] = 32'h0;
    @(negedge clk);
  endtask

  task automatic preload(input int a, input logic [31:0] d);
    pl_en = 1'b1; pl_addr = 6'(a); pl_data = d; ref_mem[a] = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Issue one or two simultaneous requests from IDLE and check every ack
  // against the model: order, latency, err, read data, strobe counts.
  task automatic run_pair(input bit en0, input bit en1, input txn_t t0, input txn_t t1,
                          input string tag);
    txn_t t [2];
    bit   oor;
    int   need, nack, cyc, p, exp_p, first_p, t_first;
    int   rd_cnt, wr_cnt, exp_rd, exp_wr;
    t[0] = t0; t[1] = t1;
    need = int'(en0) + int'(en1);
    nack = 0; cyc = 0; first_p = 0; t_first = 0;
    rd_cnt = 0; wr_cnt = 0; exp_rd = 0; exp_wr = 0;
    drive(0, en0, t0);
    drive(1, en1, t1);
    while (nack < need && cyc < 30) begin
      @(negedge clk);
      cyc++;
      if (mem_read)  rd_cnt++;
      if (mem_write) wr_cnt++;
      if (ack0 || ack1) begin
        p = ack1 ? 1 : 0;
        check({tag, "_ack_onehot"}, {31'h0, ack0 & ack1}, 32'h0);
        if (nack == 0) exp_p = (en0 && en1) ? 1 - last_port : (en1 ? 1 : 0);
        else           exp_p = 1 - first_p;
        check({tag, "_port"}, 32'(p), 32'(exp_p));
        check({tag, "_latency"}, 32'(cyc), (nack == 0) ? 32'd2 : 32'(t_first + 3));
        oor = (t[p].addr >= 64);
        if (t[p].we) begin
          if (!oor) begin ref_mem[t[p].addr[5:0]] = t[p].wdata; exp_wr++; end
        end else begin
          exp_rdata[p] = oor ? 32'h0 : ref_mem[t[p].addr[5:0]];
          if (!oor) exp_rd++;
        end
        check({tag, "_err"}, {31'h0, (p == 1) ? err1 : err0}, {31'h0, oor});
        check({tag, "_rdata"}, (p == 1) ? rdata1 : rdata0, exp_rdata[p]);
        check({tag, "_rdata_other"}, (p == 1) ? rdata0 : rdata1, exp_rdata[1 - p]);
        last_port = p;
        if (nack == 0) begin first_p = p; t_first = cyc; end
        drive(p, 0, t[p]);
        nack++;
      end
    end
    check({tag, "_all_acked"}, 32'(nack), 32'(need));
    check({tag, "_reads"}, 32'(rd_cnt), 32'(exp_rd));
    check({tag, "_writes"}, 32'(wr_cnt), 32'(exp_wr));
    @(negedge clk);
  endtask

  initial begin
    txn_t ta, tb, tn;
    int   n, cyc, p, mism, ack_cyc [4], ack_port [4];
    tn = '{0, 32'h0, 32'h0};
    rst = 1'b0;
    drive(0, 0, tn);
    drive(1, 0, tn);

    // Reset values, then fill memory with known random contents.
    do_reset();
    for (int i = 0; i < 64; i++) preload(i, $urandom);

    // Single read of a preloaded word.
    preload(5, 32'hDEADBEEF);
    run_pair(1, 0, '{0, 32'd5, 32'h0}, tn, "single_read");

    // Port 1 write then read back at the top address.
    run_pair(0, 1, tn, '{1, 32'd63, 32'h12345678}, "p1_write63");
    run_pair(0, 1, tn, '{0, 32'd63, 32'h0}, "p1_read63");
    check("p1_readback_val", rdata1, 32'h12345678);

    // Contention from reset: both ports held for four transactions.
    do_reset();
    drive(0, 1, '{0, 32'd5, 32'h0});
    drive(1, 1, '{0, 32'd63, 32'h0});
    n = 0; cyc = 0;
    while (n < 4 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (ack0 || ack1) begin
        check("cont_ack_onehot", {31'h0, ack0 & ack1}, 32'h0);
        ack_port[n] = ack1 ? 1 : 0;
        ack_cyc[n]  = cyc;
        p = ack_port[n];
        exp_rdata[p] = ref_mem[(p == 1) ? 63 : 5];
        check("cont_rdata", (p == 1) ? rdata1 : rdata0, exp_rdata[p]);
        n++;
        if (n == 4) begin drive(0, 0, tn); drive(1, 0, tn); end
      end
    end
    check("cont_count", 32'(n), 32'd4);
    for (int i = 0; i < n; i++) begin
      check("cont_order", 32'(ack_port[i]), 32'(i % 2));
      check("cont_spacing", 32'(ack_cyc[i]), 32'(2 + 3 * i));
    end
    last_port = 1;
    @(negedge clk);

    // Out-of-range write and read on port 0.
    run_pair(1, 0, '{1, 32'd64, 32'hBAD0BAD0}, tn, "oor_write");
    run_pair(1, 0, '{0, 32'hFFFF_FFFF, 32'h0}, tn, "oor_read");
    mism = 0;
    for (int i = 0; i < 64; i++) if (dmem[i] !== ref_mem[i]) mism++;
    check("oor_mem_intact", 32'(mism), 32'h0);

    // Reset asserted during the ACCESS cycle of a write.
    drive(0, 1, '{1, 32'd7, 32'hA5A5_5A5A});
    @(negedge clk);
    check("midrst_write_hi", {31'h0, mem_write}, 32'h1);
    #1 rst = 1'b0;
    #1 check("midrst_write_drop", {31'h0, mem_write}, 32'h0);
    drive(0, 0, tn);
    @(negedge clk);
    check("midrst_no_ack", {30'h0, ack1, ack0}, 32'h0);
    check("midrst_rdata0", rdata0, 32'h0);
    rst = 1'b1;
    last_port = 1;
    exp_rdata[0] = 32'h0;
    exp_rdata[1] = 32'h0;
    run_pair(1, 0, '{1, 32'd7, 32'h0BAD_F00D}, tn, "midrst_rewrite");
    run_pair(1, 0, '{0, 32'd7, 32'h0}, tn, "midrst_readback");

    // Late request: port 1 rises during DONE of a port-0 transaction.
    drive(0, 1, '{0, 32'd12, 32'h0});
    cyc = 0;
    while (!ack0 && cyc < 10) begin @(negedge clk); cyc++; end
    check("late_ack0_seen", {31'h0, ack0}, 32'h1);
    exp_rdata[0] = ref_mem[12];
    check("late_rdata0", rdata0, exp_rdata[0]);
    drive(0, 0, tn);
    drive(1, 1, '{0, 32'd33, 32'h0});
    cyc = 0;
    while (!ack1 && cyc < 10) begin @(negedge clk); cyc++; end
    check("late_ack1_gap", 32'(cyc), 32'd3);
    exp_rdata[1] = ref_mem[33];
    check("late_rdata1", rdata1, exp_rdata[1]);
    drive(1, 0, tn);
    last_port = 1;
    @(negedge clk);

    // Randomised mix of single and contended requests.
    for (int r = 0; r < 40; r++) begin
      bit e0, e1;
      e0 = 1'($urandom);
      e1 = 1'($urandom);
      if (!e0 && !e1) e0 = 1'b1;
      ta.we = 1'($urandom); ta.wdata = $urandom;
      tb.we = 1'($urandom); tb.wdata = $urandom;
      ta.addr = ($urandom_range(0, 7) == 0) ? ($urandom | 32'h40) : 32'($urandom_range(0, 63));
      tb.addr = ($urandom_range(0, 7) == 0) ? ($urandom | 32'h40) : 32'($urandom_range(0, 63));
      run_pair(e0, e1, ta, tb, "rand");
    end
    mism = 0;
    for (int i = 0; i < 64; i++) if (dmem[i] !== ref_mem[i]) mism++;
    check("rand_mem_final", 32'(mism), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
